// File: rtl/vga_fb_arb_pkg.sv
// Shared geometry, widths and slot types for the VGA framebuffer arbiter.
package vga_fb_arb_pkg;

    localparam int unsigned H_ACTIVE       = 800;
    localparam int unsigned V_ACTIVE       = 600;
    localparam int unsigned PIX_W          = 8;
    localparam int unsigned WORD_W         = 2 * PIX_W;
    localparam int unsigned ADDR_W         = 18;
    localparam int unsigned COORD_W        = 11;
    localparam int unsigned WORDS_PER_LINE = H_ACTIVE / 2;
    localparam int unsigned FB_WORDS       = WORDS_PER_LINE * V_ACTIVE;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_DISP = 2'd1,
        SLOT_HOST = 2'd2
    } slot_e;

    // First word of a line: row*400 = (row<<8) + (row<<7) + (row<<4).
    function automatic logic [ADDR_W-1:0] line_base(input logic [COORD_W-1:0] row);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 8) + (r << 7) + (r << 4);
    endfunction

endpackage

// File: rtl/vga_fb_pix_pipe.sv
// Two-stage alignment of data enable, syncs and column parity to the RAM
// read latency, with even/odd byte selection of the fetched pixel word.
module vga_fb_pix_pipe
    import vga_fb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              odd_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [PIX_W-1:0]  pix_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    logic              de1_q, hs1_q, vs1_q, odd1_q;
    logic              de2_q, hs2_q, vs2_q;
    logic [WORD_W-1:0] word_q, word_d;
    logic [PIX_W-1:0]  pix_q, pix_d;

    // Even column shows the fresh low byte and keeps the word for its odd partner.
    always_comb begin
        word_d = word_q;
        pix_d  = '0;
        if (de1_q) begin
            if (odd1_q) begin
                pix_d = word_q[WORD_W-1:PIX_W];
            end else begin
                pix_d  = rdata_i[PIX_W-1:0];
                word_d = rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de1_q  <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            odd1_q <= 1'b0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            word_q <= '0;
            pix_q  <= '0;
        end else begin
            de1_q  <= de_i;
            hs1_q  <= hsync_i;
            vs1_q  <= vsync_i;
            odd1_q <= odd_i;
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            word_q <= word_d;
            pix_q  <= pix_d;
        end
    end

    assign pix_o   = pix_q;
    assign de_o    = de2_q;
    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter sharing one pixel RAM between the display scan and a host.
// Optional host read path: define VGA_FB_ARB_HOST_READ_EN.
module vga_fb_arbiter
    import vga_fb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_ready,
    input  logic [COORD_W-1:0] disp_col,
    input  logic [COORD_W-1:0] disp_row,
    input  logic               disp_hsync,
    input  logic               disp_vsync,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [WORD_W-1:0]  host_wdata,
    output logic               host_ack,
    output logic [WORD_W-1:0]  host_rdata,
    output logic               host_rvalid,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]   vga_pix,
    output logic               vga_de,
    output logic               vga_hsync,
    output logic               vga_vsync
);

    slot_e slot_c;
    logic  disp_active;
    logic  host_in_range;
    logic  host_wr;

    assign disp_active   = disp_ready
                         && (disp_col < COORD_W'(H_ACTIVE))
                         && (disp_row < COORD_W'(V_ACTIVE));
    assign host_in_range = host_addr < ADDR_W'(FB_WORDS);

`ifdef VGA_FB_ARB_HOST_READ_EN
    assign host_wr = host_we;
`else
    logic unused_host_we;
    assign unused_host_we = host_we;
    assign host_wr        = 1'b1;
`endif

    // Display owns even active columns; every other cycle is free for the host.
    always_comb begin
        slot_c    = SLOT_IDLE;
        host_ack  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (disp_active && !disp_col[0]) begin
                slot_c = SLOT_DISP;
            end else if (host_req) begin
                slot_c = SLOT_HOST;
            end
        end
        case (slot_c)
            SLOT_DISP: begin
                mem_en   = 1'b1;
                mem_addr = line_base(disp_row) + ADDR_W'(disp_col[COORD_W-1:1]);
            end
            SLOT_HOST: begin
                host_ack  = 1'b1;
                mem_en    = host_in_range;
                mem_we    = host_in_range && host_wr;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: ;
        endcase
    end

`ifdef VGA_FB_ARB_HOST_READ_EN
    logic              rd_pend_q, rd_pend_d;
    logic              rd_oob_q, rd_oob_d;
    logic              rvalid_q;
    logic [WORD_W-1:0] rdata_q;

    assign rd_pend_d = (slot_c == SLOT_HOST) && !host_wr;
    assign rd_oob_d  = !host_in_range;

    // RAM data lands one cycle after the strobe; out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_oob_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_oob_q  <= rd_oob_d;
            rvalid_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rdata_q <= rd_oob_q ? '0 : mem_rdata;
            end
        end
    end

    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
`else
    assign host_rvalid = 1'b0;
    assign host_rdata  = '0;
`endif

    vga_fb_pix_pipe u_pix_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .de_i    (disp_active),
        .hsync_i (disp_hsync),
        .vsync_i (disp_vsync),
        .odd_i   (disp_col[0]),
        .rdata_i (mem_rdata),
        .pix_o   (vga_pix),
        .de_o    (vga_de),
        .hsync_o (vga_hsync),
        .vsync_o (vga_vsync)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, cycle-level reference model and directed scenarios.
module tb_vga_fb_arbiter;

    localparam int FB = 240000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        disp_ready = 1'b0;
    logic [10:0] disp_col = '0;
    logic [10:0] disp_row = '0;
    logic        disp_hsync = 1'b1;
    logic        disp_vsync = 1'b1;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [17:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        host_rvalid;
    logic        mem_en, mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  vga_pix;
    logic        vga_de, vga_hsync, vga_vsync;

    int checks = 0;
    int errors = 0;

    vga_fb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_ready(disp_ready), .disp_col(disp_col), .disp_row(disp_row),
        .disp_hsync(disp_hsync), .disp_vsync(disp_vsync),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .vga_pix(vga_pix), .vga_de(vga_de), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    bit [15:0] ram [FB];
    always @(posedge clk) begin
        if (mem_en && int'(mem_addr) < FB) begin
            if (mem_we) ram[int'(mem_addr)] <= mem_wdata;
            else        mem_rdata <= ram[int'(mem_addr)];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs derived from the arbitration rules.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] pix;
        logic       rv;
        logic [15:0] rd;
    } ent_t;
    localparam ent_t RST_ENT = '{de:1'b0, hs:1'b1, vs:1'b1, pix:8'h0, rv:1'b0, rd:16'h0};

    bit [15:0] ref_mem [FB];
    ent_t      h1 = RST_ENT, h2 = RST_ENT, e;
    bit [15:0] last_word = '0;
    bit        m_active, m_dslot, m_ack, m_inr, m_wr, m_rd;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ack", 32'(host_ack), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            chk("rst_rvalid", 32'(host_rvalid), 0);
            chk("rst_rdata", 32'(host_rdata), 0);
            chk("rst_de", 32'(vga_de), 0);
            chk("rst_pix", 32'(vga_pix), 0);
            chk("rst_hsync", 32'(vga_hsync), 1);
            chk("rst_vsync", 32'(vga_vsync), 1);
            h1 = RST_ENT;
            h2 = RST_ENT;
        end else begin
            m_active = disp_ready && int'(disp_col) < 800 && int'(disp_row) < 600;
            m_dslot  = m_active && (disp_col % 2 == 0);
            m_ack    = host_req && !m_dslot;
            m_inr    = int'(host_addr) < FB;
`ifdef VGA_FB_ARB_HOST_READ_EN
            m_wr = m_ack && m_inr && host_we;
            m_rd = m_ack && !host_we;
`else
            m_wr = m_ack && m_inr;
            m_rd = 1'b0;
            chk("rdata_tied", 32'(host_rdata), 0);
`endif
            chk("ack", 32'(host_ack), 32'(m_ack));
            chk("mem_en", 32'(mem_en), 32'(m_dslot || (m_ack && m_inr)));
            chk("mem_we", 32'(mem_we), 32'(m_wr));
            if (m_dslot)
                chk("disp_addr", 32'(mem_addr), 32'(int'(disp_row) * 400 + int'(disp_col) / 2));
            else if (m_ack && m_inr)
                chk("host_addr", 32'(mem_addr), 32'(host_addr));
            if (m_wr) chk("mem_wdata", 32'(mem_wdata), 32'(host_wdata));
            chk("vga_de", 32'(vga_de), 32'(h2.de));
            chk("vga_hsync", 32'(vga_hsync), 32'(h2.hs));
            chk("vga_vsync", 32'(vga_vsync), 32'(h2.vs));
            chk("vga_pix", 32'(vga_pix), 32'(h2.pix));
            chk("rvalid", 32'(host_rvalid), 32'(h2.rv));
            if (h2.rv) chk("rdata", 32'(host_rdata), 32'(h2.rd));

            e     = RST_ENT;
            e.de  = m_active;
            e.hs  = disp_hsync;
            e.vs  = disp_vsync;
            e.rv  = m_rd;
            if (m_active) begin
                if (m_dslot) begin
                    last_word = ref_mem[int'(disp_row) * 400 + int'(disp_col) / 2];
                    e.pix = last_word[7:0];
                end else begin
                    e.pix = last_word[15:8];
                end
            end
            if (m_rd && m_inr) e.rd = ref_mem[int'(host_addr)];
            if (m_wr) ref_mem[int'(host_addr)] = host_wdata;
            h2 = h1;
            h1 = e;
        end
    end

    // Directed stimulus; inputs change only 1 time unit after a rising edge.
    logic [7:0]  lpix[$];
    bit          lde[$], lhs[$], lack[$], lrv[$];
    int          lmaddr[$];
    logic [15:0] lrd[$];

    task automatic step(input logic rdy, input int col, input int row);
        @(posedge clk); #1;
        disp_ready = rdy;
        disp_col   = 11'(col);
        disp_row   = 11'(row);
    endtask

    task automatic scan(input int row, input int c0, input int n, input int hs_low);
        lpix.delete(); lde.delete(); lhs.delete(); lack.delete(); lmaddr.delete();
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) step(1'b1, c0 + i, row);
            else       step(1'b0, 0, 0);
            disp_hsync = (i == hs_low) ? 1'b0 : 1'b1;
            @(negedge clk);
            lpix.push_back(vga_pix);
            lde.push_back(vga_de);
            lhs.push_back(vga_hsync);
            lack.push_back(host_ack);
            lmaddr.push_back(int'(mem_addr));
        end
    endtask

    task automatic watch(input int n);
        lrv.delete(); lrd.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) step(1'b0, 0, 0);
            @(negedge clk);
            lrv.push_back(host_rvalid);
            lrd.push_back(host_rdata);
        end
    endtask

    task automatic host_txn(input logic we, input int addr, input logic [15:0] wd,
                            output bit en_at_ack);
        bit got;
        got = 1'b0;
        en_at_ack = 1'b0;
        step(1'b0, 0, 0);
        host_req = 1'b1; host_we = we; host_addr = 18'(addr); host_wdata = wd;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                en_at_ack = mem_en;
            end else begin
                step(1'b0, 0, 0);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL host_txn_timeout actual=no_ack expected=ack addr=%0d", addr);
        end
        step(1'b0, 0, 0);
        host_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit en;
        int cnt;
        host_req = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = 16'h3412;
        #2 rst_n = 1'b0;
        repeat (3) step(1'b0, 0, 0);
        @(negedge clk);
        chk("lit_rst_ack", 32'(host_ack), 0);
        chk("lit_rst_hsync", 32'(vga_hsync), 1);
        chk("lit_rst_vsync", 32'(vga_vsync), 1);
        chk("lit_rst_pix", 32'(vga_pix), 0);

        step(1'b0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("lit_first_ack", 32'(host_ack), 1);
        step(1'b0, 0, 0);
        host_req = 1'b0;
        host_txn(1'b1, 1, 16'h7856, en);

        scan(0, 0, 4, 1);
        chk("lit_pix_col0", 32'(lpix[2]), 32'h12);
        chk("lit_pix_col1", 32'(lpix[3]), 32'h34);
        chk("lit_pix_col2", 32'(lpix[4]), 32'h56);
        chk("lit_pix_col3", 32'(lpix[5]), 32'h78);
        chk("lit_de_before", 32'(lde[1]), 0);
        chk("lit_de_first", 32'(lde[2]), 1);
        chk("lit_de_after", 32'(lde[6]), 0);
        chk("lit_hsync_lag", 32'(lhs[3]), 0);

        scan(0, 798, 4, -1);
        chk("lit_de_col799", 32'(lde[3]), 1);
        chk("lit_de_col800", 32'(lde[4]), 0);
        scan(600, 0, 2, -1);
        chk("lit_de_row600", 32'(lde[2]), 0);

        host_txn(1'b1, 2005, 16'hCAFE, en);
        chk("lit_write_en", 32'(en), 1);

        step(1'b0, 0, 0);
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'd5000; host_wdata = 16'hBEEF;
        scan(5, 0, 20, -1);
        step(1'b0, 0, 0);
        host_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) cnt += int'(lack[i]);
        chk("lit_ack_count_line", 32'(cnt), 10);
        chk("lit_no_ack_col10", 32'(lack[10]), 0);
        chk("lit_ack_col11", 32'(lack[11]), 1);
        chk("lit_addr_col10", 32'(lmaddr[10]), 2005);

        host_txn(1'b0, 2005, 16'h5A5A, en);
        watch(4);
`ifdef VGA_FB_ARB_HOST_READ_EN
        chk("lit_rv_ack1", 32'(lrv[0]), 0);
        chk("lit_rv_ack2", 32'(lrv[1]), 1);
        chk("lit_rv_ack3", 32'(lrv[2]), 0);
        chk("lit_rdata", 32'(lrd[1]), 32'hCAFE);
        scan(5, 10, 2, -1);
        chk("lit_pix_2005_lo", 32'(lpix[2]), 32'hFE);
        chk("lit_pix_2005_hi", 32'(lpix[3]), 32'hCA);
`else
        cnt = 0;
        foreach (lrv[i]) cnt += int'(lrv[i]);
        chk("lit_no_rvalid", 32'(cnt), 0);
        scan(5, 10, 2, -1);
        chk("lit_pix_2005_lo", 32'(lpix[2]), 32'h5A);
        chk("lit_pix_2005_hi", 32'(lpix[3]), 32'h5A);
`endif

        host_txn(1'b0, 240000, 16'h0000, en);
        chk("lit_oob_en", 32'(en), 0);
        watch(3);
`ifdef VGA_FB_ARB_HOST_READ_EN
        chk("lit_oob_rv", 32'(lrv[1]), 1);
        chk("lit_oob_rdata", 32'(lrd[1]), 0);
`else
        chk("lit_oob_rv", 32'(lrv[1]), 0);
`endif

        step(1'b1, 20, 5);
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'd3; host_wdata = 16'hFFFF;
        @(negedge clk);
        chk("lit_wait_disp_slot", 32'(host_ack), 0);
        step(1'b1, 21, 5);
        host_req = 1'b0;
        @(negedge clk);
        chk("lit_dropped_req", 32'(mem_we), 0);
        scan(0, 6, 2, -1);
        chk("lit_word3_untouched", 32'(lpix[2]), 0);

        host_txn(1'b0, 2005, 16'h1111, en);
        rst_n = 1'b0;
        step(1'b0, 0, 0);
        rst_n = 1'b1;
        watch(4);
        cnt = 0;
        foreach (lrv[i]) cnt += int'(lrv[i]);
        chk("lit_rst_drops_read", 32'(cnt), 0);
        scan(1, 0, 4, -1);
        chk("lit_de_after_rst0", 32'(lde[0]), 0);
        chk("lit_de_after_rst1", 32'(lde[1]), 0);
        chk("lit_de_after_rst2", 32'(lde[2]), 1);

        step(1'b0, 0, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Time-slot arbiter sharing one single-port pixel RAM between the 800x600@60Hz display scan and a host port. It sits directly after the VGA sync generator. During active video it reads one 16-bit word (two 8-bit pixels) on every even column and gives every other cycle to the host. It also re-aligns sync, data-enable and pixel outputs to the RAM read latency.

## Interface
- H_ACTIVE, 800, active pixels per line (even)
- V_ACTIVE, 600, active lines per frame
- PIX_W, 8, bits per pixel
- ADDR_W, 18, RAM word address width (H_ACTIVE/2*V_ACTIVE = 240000 words)
- clk  in  1  40 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- disp_ready  in  1  active-video flag from sync generator
- disp_col  in  11  column, 0-based; valid when disp_ready
- disp_row  in  11  row, 0-based; valid when disp_ready
- disp_hsync, disp_vsync  in  1  sync from generator, active low
- host_req  in  1  host request, held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  word address
- host_wdata  in  2*PIX_W  write word; low byte = even pixel
- host_ack  out  1  one-cycle grant pulse
- host_rdata  out  2*PIX_W  read data, valid with host_rvalid
- host_rvalid  out  1  one-cycle read-return pulse
- mem_en, mem_we  out  1  RAM strobe and write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  2*PIX_W  RAM write data
- mem_rdata  in  2*PIX_W  RAM read data, valid the cycle after a read strobe
- vga_pix  out  PIX_W  pixel; 0 outside active video
- vga_de  out  1  aligned data enable
- vga_hsync, vga_vsync  out  1  aligned syncs

## Operation
- Display slot: cycle where disp_ready=1, disp_col<H_ACTIVE, disp_row<V_ACTIVE and disp_col[0]=0.
  - mem_en=1, mem_we=0.
  - mem_addr = disp_row*(H_ACTIVE/2) + disp_col[10:1], computed by shift-add with no multiplier.
- disp_ready=1 with disp_col or disp_row out of range: treated as blank. vga_de=0, no RAM access.
- Free slot: every other cycle. If host_req=1 in a free slot:
  - host_ack=1 in that cycle.
  - mem_* driven from host_*.
- Display always has priority. A host request never gets ack in a display slot and waits there.
- Host read return: mem_rdata is captured at the end of cycle t+1. host_rdata and host_rvalid are presented in cycle t+2.
- host_addr >= H_ACTIVE/2*V_ACTIVE:
  - Still acked.
  - mem_en held 0.
  - A read returns 0 with host_rvalid.
- Pixel pipeline:
  - Even column: vga_pix takes the low byte of mem_rdata.
  - Odd column: vga_pix takes the high byte of a word register captured at the even column.
- mem_en/mem_we/mem_addr/mem_wdata/host_ack are combinational from the current inputs. Every other output is registered.

## Timing
- vga_pix, vga_de, vga_hsync and vga_vsync lag disp_* by exactly 2 cycles. Syncs are delayed through the same pipeline.
- Host write: committed in the ack cycle.
- Host read: rvalid 2 cycles after ack. At most one read is in flight per free slot.
- Back-to-back host requests during active video: one ack every 2 cycles. During blanking: one ack every cycle.
- Reset values:
  - host_ack, host_rvalid, vga_de, mem_en, mem_we: 0.
  - host_rdata, vga_pix, mem_addr, mem_wdata: 0.
  - vga_hsync and vga_vsync: 1.
- Reset mid-operation:
  - Pipeline flushed.
  - A pending read return is dropped, so no rvalid.
  - An unacked request is simply re-arbitrated after reset.
- Deasserting host_req before ack is legal and produces no access.

## Configuration
- VGA_FB_ARB_HOST_READ_EN
  - Defined: host reads work as specified.
  - Undefined: host_we is ignored and every access is a write. host_rdata and host_rvalid are tied to 0. The read-return registers are removed.

## Structure
- Package vga_fb_arb_pkg holds:
  - H_ACTIVE, V_ACTIVE and WORDS_PER_LINE (H_ACTIVE/2).
  - FB_WORDS.
  - The slot-type enum: SLOT_DISP, SLOT_HOST, SLOT_IDLE.
- Sub-module vga_fb_pix_pipe: 2-stage alignment of de/syncs/column parity plus byte select.
- The arbiter top holds slot decode, address generation and the host return path.

## Test plan
- Reset with host_req=1 → host_ack=0, vga_hsync=vga_vsync=1, vga_pix=0; first ack in the first free cycle after rst_n rises.
- Host writes 0x3412 to word 0, then a frame scans (row 0, col 0 and 1) → vga_pix=0x12 then 0x34, 2 cycles after the corresponding disp_col.
- host_req held through active line row 5 → ack only on odd-column cycles; mem_addr at col 10 = 5*400+5 = 2005 during the display slot.
- Host read of word 2005 in blanking → host_rvalid exactly 2 cycles after ack with the written data; with the macro undefined → no rvalid, write performed.
- host_addr=240000 → ack, mem_en=0, read returns 0.
- rst_n pulsed one cycle after a host read ack → no host_rvalid; vga_de=0 until the next active region plus 2 cycles.
